// File: rtl/d5m_pkg.sv
// Shared constants and capture FSM state type for the D5M pixel receive path.
package d5m_pkg;

  localparam int D5M_DATA_W   = 12;
  localparam int D5M_H_ACTIVE = 1280;
  localparam int D5M_V_ACTIVE = 960;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_IDLE = 2'd1,
    WAIT_SOF  = 2'd2,
    CAPTURE   = 2'd3
  } capture_state_t;

endpackage

// File: rtl/d5m_edge_detect.sv
// Registers a level and flags its rising/falling transitions against the previous cycle.
// Pulses are combinational from the input level and the one-cycle-old copy; no backpressure.
module d5m_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/d5m_capture.sv
// D5M sensor receive: frame-gated capture of the raw pixel bus with X/Y indices and frame count.
// Pin-to-DATA/DVAL latency is 2 PIXCLK cycles; no backpressure, the sensor stream is free-running.
module d5m_capture
  import d5m_pkg::*;
#(
  parameter int DATA_W   = D5M_DATA_W,
  parameter int H_ACTIVE = D5M_H_ACTIVE,
  parameter int V_ACTIVE = D5M_V_ACTIVE,
  parameter int CNT_W    = 12
) (
  input  logic              PIXCLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] D5M_D,
  input  logic              D5M_FVAL,
  input  logic              D5M_LVAL,
  input  logic              START,
  input  logic              STOP,
  output logic [DATA_W-1:0] DATA,
  output logic              DVAL,
  output logic [CNT_W-1:0]  X_CONT,
  output logic [CNT_W-1:0]  Y_CONT,
  output logic [31:0]       FRAME_CONT,
  output logic              CAPTURING,
  output logic              LINE_ERR
);

  capture_state_t    state;
  logic [DATA_W-1:0] rD;
  logic              rF;
  logic              rL;
  logic              f_rise;
  logic              f_fall;
  logic              l_rise;
  logic              l_fall;
  logic              stop_pend;
  logic [CNT_W-1:0]  x_cnt;
  logic [CNT_W-1:0]  y_cnt;
  logic              in_capture;
  logic              pix_vld;
  logic              line_end;
  logic              frame_end;
  logic [CNT_W-1:0]  lines_done;

  always_ff @(posedge PIXCLK) begin
    if (RESET) begin
      rD <= '0;
      rF <= 1'b0;
      rL <= 1'b0;
    end else begin
      rD <= D5M_D;
      rF <= D5M_FVAL;
      rL <= D5M_LVAL;
    end
  end

  d5m_edge_detect u_fval_edge (
    .clk   (PIXCLK),
    .rst   (RESET),
    .level (rF),
    .rise  (f_rise),
    .fall  (f_fall)
  );

  d5m_edge_detect u_lval_edge (
    .clk   (PIXCLK),
    .rst   (RESET),
    .level (rL),
    .rise  (l_rise),
    .fall  (l_fall)
  );

  assign in_capture = (state == CAPTURE);
  assign pix_vld    = rF & rL & in_capture;
  // A line only ends inside a frame; LVAL may drop together with FVAL on the last line.
  assign line_end   = in_capture & l_fall & (rF | f_fall);
  assign frame_end  = in_capture & f_fall;
  assign lines_done = y_cnt + CNT_W'(line_end);

  always_ff @(posedge PIXCLK) begin
    if (RESET) begin
      state     <= IDLE;
      stop_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          stop_pend <= 1'b0;
          if (START && !STOP) state <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (STOP)     state <= IDLE;
          else if (!rF) state <= WAIT_SOF;
        end
        WAIT_SOF: begin
          if (STOP)        state <= IDLE;
          else if (f_rise) state <= CAPTURE;
        end
        CAPTURE: begin
          if (frame_end && stop_pend) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
          end else if (STOP) begin
            stop_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge PIXCLK) begin
    if (RESET) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (f_rise && (state == WAIT_SOF || in_capture)) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (line_end) begin
      x_cnt <= '0;
      y_cnt <= y_cnt + 1'b1;
    end else if (pix_vld) begin
      x_cnt <= x_cnt + 1'b1;
    end
  end

  always_ff @(posedge PIXCLK) begin
    if (RESET) begin
      FRAME_CONT <= '0;
      LINE_ERR   <= 1'b0;
    end else begin
      if (frame_end) FRAME_CONT <= FRAME_CONT + 32'd1;
      if ((line_end && x_cnt != CNT_W'(H_ACTIVE)) ||
          (frame_end && lines_done != CNT_W'(V_ACTIVE)))
        LINE_ERR <= 1'b1;
    end
  end

  // Indices leave with the pixel they belong to, i.e. before the counter advances.
  always_ff @(posedge PIXCLK) begin
    if (RESET) begin
      DATA   <= '0;
      DVAL   <= 1'b0;
      X_CONT <= '0;
      Y_CONT <= '0;
    end else begin
      DATA   <= rD;
      DVAL   <= pix_vld;
      X_CONT <= x_cnt;
      Y_CONT <= y_cnt;
    end
  end

  assign CAPTURING = in_capture;

endmodule

// File: tb/tb_d5m_capture.sv
// Frame-level reference model of the capture gating, fed with randomized sensor frames.
module tb_d5m_capture;

  localparam int DW = 12;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int CW = 12;

  logic          PIXCLK   = 1'b0;
  logic          RESET    = 1'b1;
  logic [DW-1:0] D5M_D    = '0;
  logic          D5M_FVAL = 1'b0;
  logic          D5M_LVAL = 1'b0;
  logic          START    = 1'b0;
  logic          STOP     = 1'b0;
  logic [DW-1:0] DATA;
  logic          DVAL;
  logic [CW-1:0] X_CONT;
  logic [CW-1:0] Y_CONT;
  logic [31:0]   FRAME_CONT;
  logic          CAPTURING;
  logic          LINE_ERR;

  d5m_capture #(
    .DATA_W   (DW),
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .CNT_W    (CW)
  ) dut (
    .PIXCLK     (PIXCLK),
    .RESET      (RESET),
    .D5M_D      (D5M_D),
    .D5M_FVAL   (D5M_FVAL),
    .D5M_LVAL   (D5M_LVAL),
    .START      (START),
    .STOP       (STOP),
    .DATA       (DATA),
    .DVAL       (DVAL),
    .X_CONT     (X_CONT),
    .Y_CONT     (Y_CONT),
    .FRAME_CONT (FRAME_CONT),
    .CAPTURING  (CAPTURING),
    .LINE_ERR   (LINE_ERR)
  );

  always #5 PIXCLK = ~PIXCLK;

  int cyc = 0;
  always @(posedge PIXCLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    int            x;
    int            y;
    int            c;
  } pix_t;

  pix_t expq[$];

  // Reference model state: whether a frame start will be captured, whether we are capturing.
  bit m_armed  = 0;
  bit m_cap    = 0;
  bit m_stop   = 0;
  bit m_err    = 0;
  int m_frames = 0;
  int m_lines  = 0;
  int lens[16];

  always @(negedge PIXCLK) begin
    pix_t p;
    if (DVAL !== 1'b0) begin
      if (expq.size() == 0) begin
        check("unexpected_dval", 64'(DVAL), 64'd0);
      end else begin
        p = expq.pop_front();
        check("dval", 64'(DVAL), 64'd1);
        check("data", 64'(DATA), 64'(p.d));
        check("x_cont", 64'(X_CONT), 64'(p.x));
        check("y_cont", 64'(Y_CONT), 64'(p.y));
        check("latency", 64'(cyc - p.c), 64'd2);
      end
    end
  end

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom);
  endfunction

  task automatic drive(input bit f, input bit l, input logic [DW-1:0] d,
                       input bit s, input bit p, input bit r);
    D5M_FVAL = f;
    D5M_LVAL = l;
    D5M_D    = d;
    START    = s;
    STOP     = p;
    RESET    = r;
    @(posedge PIXCLK);
    #1;
  endtask

  task automatic model_ctrl(input bit s, input bit p);
    if (p) begin
      if (m_cap) m_stop = 1;
      else       m_armed = 0;
    end else if (s && !m_cap) begin
      m_armed = 1;
    end
  endtask

  task automatic ctrl(input bit s, input bit p);
    model_ctrl(s, p);
    drive(0, 0, rnd(), s, p, 0);
    repeat (3) drive(0, 0, rnd(), 0, 0, 0);
    check("ctrl_capturing", 64'(CAPTURING), 64'(m_cap));
  endtask

  task automatic set_lens();
    for (int i = 0; i < 16; i++) lens[i] = H;
  endtask

  task automatic model_reset();
    expq.delete();
    m_armed  = 0;
    m_cap    = 0;
    m_stop   = 0;
    m_err    = 0;
    m_frames = 0;
  endtask

  task automatic frame(input int nl, input int start_at, input int stop_at, input int rst_at);
    logic [DW-1:0] d;
    bit s;
    bit p;
    pix_t e;
    if (m_armed) begin
      m_cap   = 1;
      m_armed = 0;
    end
    m_lines = 0;
    repeat (3) drive(1, 0, rnd(), 0, 0, 0);
    for (int i = 0; i < nl; i++) begin
      for (int j = 0; j < lens[i]; j++) begin
        d = rnd();
        if (rst_at == i && j == 3) begin
          drive(1, 1, d, 0, 0, 1);
          model_reset();
          check("rst_dval", 64'(DVAL), 64'd0);
          check("rst_x", 64'(X_CONT), 64'd0);
          check("rst_y", 64'(Y_CONT), 64'd0);
          check("rst_frames", 64'(FRAME_CONT), 64'd0);
          check("rst_capturing", 64'(CAPTURING), 64'd0);
          check("rst_line_err", 64'(LINE_ERR), 64'd0);
        end else begin
          s = (start_at == i && j == 2);
          p = (stop_at == i && j == 2);
          if (m_cap) begin
            e.d = d;
            e.x = j;
            e.y = m_lines;
            e.c = cyc;
            expq.push_back(e);
          end
          model_ctrl(s, p);
          drive(1, 1, d, s, p, 0);
        end
      end
      if (m_cap) begin
        if (lens[i] != H) m_err = 1;
        m_lines++;
      end
      repeat (3) drive(1, 0, rnd(), 0, 0, 0);
      check("line_err_eol", 64'(LINE_ERR), 64'(m_err));
    end
    if (m_cap) begin
      m_frames++;
      if (m_lines != V) m_err = 1;
      if (m_stop) begin
        m_cap  = 0;
        m_stop = 0;
      end
    end
    repeat ($urandom_range(5, 8)) drive(0, 0, rnd(), 0, 0, 0);
    check("frame_cont", 64'(FRAME_CONT), 64'(m_frames));
    check("line_err_eof", 64'(LINE_ERR), 64'(m_err));
    check("capturing", 64'(CAPTURING), 64'(m_cap));
    check("pixels_pending", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    int nl;
    set_lens();

    // Reset state.
    repeat (3) drive(0, 0, rnd(), 0, 0, 1);
    drive(0, 0, rnd(), 0, 0, 0);
    check("reset_dval", 64'(DVAL), 64'd0);
    check("reset_data", 64'(DATA), 64'd0);
    check("reset_x", 64'(X_CONT), 64'd0);
    check("reset_y", 64'(Y_CONT), 64'd0);
    check("reset_frames", 64'(FRAME_CONT), 64'd0);
    check("reset_capturing", 64'(CAPTURING), 64'd0);
    check("reset_line_err", 64'(LINE_ERR), 64'd0);

    // Basic 4x8 frame, then a continuous frame, then STOP during line 1.
    ctrl(1, 0);
    frame(V, -1, -1, -1);
    frame(V, -1, -1, -1);
    frame(V, -1, 1, -1);
    frame(V, -1, -1, -1);

    // START mid-frame: that frame is skipped, the next is captured; STOP in vblank ends after one more.
    frame(V, 1, -1, -1);
    frame(V, -1, -1, -1);
    ctrl(0, 1);
    frame(V, -1, -1, -1);
    frame(V, -1, -1, -1);

    // START then START+STOP together while waiting for a frame start.
    ctrl(1, 0);
    ctrl(1, 1);
    frame(V, -1, -1, -1);

    // Reset in the middle of a captured line, then a fresh capture.
    ctrl(1, 0);
    frame(V, -1, -1, 1);
    ctrl(1, 0);
    frame(V, -1, -1, -1);

    // Short line flags the error, which stays set through a clean frame.
    lens[2] = 7;
    frame(V, -1, -1, -1);
    set_lens();
    frame(V, -1, -1, -1);

    // Randomized frame geometry while capturing.
    for (int k = 0; k < 6; k++) begin
      nl = $urandom_range(3, 5);
      for (int i = 0; i < 16; i++) lens[i] = $urandom_range(7, 9);
      frame(nl, -1, -1, -1);
    end
    set_lens();
    ctrl(0, 1);
    frame(V, -1, -1, -1);
    frame(V, -1, -1, -1);

    // Only reset clears the sticky error.
    drive(0, 0, rnd(), 0, 0, 1);
    model_reset();
    drive(0, 0, rnd(), 0, 0, 0);
    check("final_line_err", 64'(LINE_ERR), 64'd0);
    check("final_frames", 64'(FRAME_CONT), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
